// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 codes, unit state and constants.
package rv32m_pkg;

    localparam int XLEN_D = 32;
    localparam int ITER_D = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline (master) and the M unit (slave).
interface ex_muldiv_if
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_D
);
    logic            ex_valid;
    logic            ex_kill;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            md_busy;

    modport master (
        output ex_valid, ex_kill, ex_funct3, ex_rs1, ex_rs2,
        input  md_stall, md_done, md_result, md_busy
    );

    modport slave (
        input  ex_valid, ex_kill, ex_funct3, ex_rs1, ex_rs2,
        output md_stall, md_done, md_result, md_busy
    );
endinterface

// File: rtl/md_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] lo_init_i,
    input  logic [XLEN-1:0] opb_init_i,
    output logic [XLEN-1:0] nxt_hi_o,
    output logic [XLEN-1:0] nxt_lo_o
);
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d, opb_q;
    logic [XLEN:0]   sum, rem;
    logic [XLEN+1:0] diff;

    // hi/lo hold {product high, multiplier} or {remainder, quotient}
    always_comb begin
        sum  = hi_q + (lo_q[0] ? {1'b0, opb_q} : '0);
        rem  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        diff = {1'b0, rem} - {2'b00, opb_q};
        hi_d = {1'b0, sum[XLEN:1]};
        lo_d = {sum[0], lo_q[XLEN-1:1]};
        if (is_div_i) begin
            if (!diff[XLEN+1]) begin
                hi_d = diff[XLEN:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rem;
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= lo_init_i;
            opb_q <= opb_init_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign nxt_hi_o = hi_d[XLEN-1:0];
    assign nxt_lo_o = lo_d;
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit; stalls the front end while busy.
module ex_muldiv
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int ITER = ITER_D
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    md_state_e       state_q;
    logic [2:0]      f3_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] res_q;

    logic [2:0]      f3;
    logic [XLEN-1:0] rs1, rs2, a_mag, b_mag;
    logic            sa, sb, is_div, neg, div0, ovf, special, accept;
    logic [XLEN-1:0] spec_res, fin_res, nxt_hi, nxt_lo, quo, rmd;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        f3     = bus.ex_funct3;
        rs1    = bus.ex_rs1;
        rs2    = bus.ex_rs2;
        is_div = f3[2];
        sa     = (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
                 (f3 == F3_DIV)  || (f3 == F3_REM);
        sb     = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
        a_mag  = (sa && rs1[XLEN-1]) ? -rs1 : rs1;
        b_mag  = (sb && rs2[XLEN-1]) ? -rs2 : rs2;
        // remainder follows the dividend, quotient the xor of signs
        if (is_div)
            neg = f3[1] ? (sa & rs1[XLEN-1])
                        : (sa & (rs1[XLEN-1] ^ rs2[XLEN-1]));
        else
            neg = (sa & rs1[XLEN-1]) ^ (sb & rs2[XLEN-1]);
        div0     = is_div && (rs2 == '0);
        ovf      = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
                   (rs1 == INT_MIN) && (rs2 == ALL_ONES);
        special  = div0 || ovf;
        spec_res = div0 ? (f3[1] ? rs1 : ALL_ONES)
                        : (f3[1] ? '0 : INT_MIN);
        accept   = (state_q == IDLE) && bus.ex_valid && !bus.ex_kill;
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && !special),
        .step_i     ((state_q == BUSY) && !bus.ex_kill),
        .is_div_i   (f3_q[2]),
        .lo_init_i  (is_div ? a_mag : b_mag),
        .opb_init_i (is_div ? b_mag : a_mag),
        .nxt_hi_o   (nxt_hi),
        .nxt_lo_o   (nxt_lo)
    );

    always_comb begin
        prod = {nxt_hi, nxt_lo};
        if (neg_q) prod = -prod;
        quo = neg_q ? -nxt_lo : nxt_lo;
        rmd = neg_q ? -nxt_hi : nxt_hi;
        if (f3_q[2])
            fin_res = f3_q[1] ? rmd : quo;
        else if (f3_q == F3_MUL)
            fin_res = prod[XLEN-1:0];
        else
            fin_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (bus.ex_kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.ex_valid) begin
                    f3_q  <= f3;
                    neg_q <= neg;
                    cnt_q <= '0;
                    if (special) begin
                        res_q   <= spec_res;
                        state_q <= DONE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        res_q   <= fin_res;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.md_stall  = accept || ((state_q == BUSY) && !bus.ex_kill);
    assign bus.md_done   = (state_q == DONE) && !bus.ex_kill;
    assign bus.md_busy   = (state_q == BUSY);
    assign bus.md_result = res_q;
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and funct3 held in the ID/EX pipeline register. While an operation is in flight it raises a stall that freezes PC, IF/ID and ID/EX. When finished it presents a 32-bit result for the EX result mux to forward into EX/MEM.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITER, 32, iterations per multiply or divide (one bit per cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  instruction in EX is RV32M (opcode 0110011, funct7 0000001).
- ex_kill  in  1  squash the EX instruction; abort any operation.
- ex_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_rs1  in  32  forwarded operand A (dividend or multiplicand).
- ex_rs2  in  32  forwarded operand B (divisor or multiplier).
- md_stall  out  1  freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- md_done  out  1  md_result valid this cycle; the pipeline advances at the next edge.
- md_result  out  32  result.
- md_busy  out  1  state is BUSY (debug/perf counter).

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- md_stall is combinational: (IDLE & ex_valid & ~ex_kill) | BUSY.
- IDLE with ex_valid & ~ex_kill:
  - Latch funct3 and operand magnitudes (signed ops take abs; MULHSU takes abs of rs1 only). Latch the result-sign flag. Clear the iteration counter.
  - Go to BUSY, or go straight to DONE on a special case.
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- BUSY, one step per cycle, counter 0..ITER-1:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, with a 33-bit partial remainder.
  - After step ITER-1, apply sign fix, register md_result and go to DONE.
- Sign fix:
  - Product: two's-complement negate the 64-bit value when the sign flag is set. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
  - Quotient: negated when operand signs differ (signed ops only).
  - Remainder: takes the dividend's sign.
- DONE: md_done=1, md_stall=0, md_result held. Next edge goes to IDLE unconditionally. The same instruction, still visible on ex_valid in DONE, is never restarted.
- ex_kill in any state: md_stall=0 that cycle, next state IDLE, md_done forced 0, result discarded.
- ex_funct3, ex_rs1 and ex_rs2 are ignored after acceptance; only latched copies are used.

## Timing
- Reset values: state IDLE, md_done 0, md_busy 0, md_result 0x00000000, counter 0. md_stall equals ex_valid & ~ex_kill during and after reset.
- Normal op: accept at edge E0, BUSY for edges E1..E32, DONE in the cycle after E32.
  - EX residency is 34 cycles.
  - md_stall is high for 33 cycles, from the arrival cycle through the last BUSY cycle.
- Special case: accept at E0, DONE in the next cycle. EX residency is 2 cycles; md_stall is high for 1 cycle.
- Back-to-back M ops: the second op reaches EX in the cycle after DONE and sees IDLE. No dead cycle is required beyond DONE.
- rst_n asserted mid-BUSY: immediate return to IDLE with all outputs at reset values. No partial result is ever flagged done.
- ex_kill and DONE in the same cycle: kill wins; md_done=0.

## Structure
- Package rv32m_pkg:
  - funct3 localparams F3_MUL..F3_REMU.
  - State enum IDLE/BUSY/DONE.
  - XLEN and ITER defaults.
  - Constants INT_MIN=0x80000000 and ALL_ONES.
- One sub-module, md_iter_core: the per-cycle shift-add and restoring-subtract datapath plus accumulator registers.
- The top level holds the FSM, special-case detection, abs/sign-fix logic and stall generation.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → md_result 0xFFFFFFEB. md_done in cycle 34 after arrival; md_stall high for exactly 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9÷2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100÷7 → 14. REMU 100÷7 → 2.
- DIVU 0x1234÷0 → 0xFFFFFFFF and REMU → 0x1234, each with 2-cycle residency. DIV 0x80000000÷0xFFFFFFFF → 0x80000000 and REM → 0, each with 2-cycle residency.
- Assert rst_n low at BUSY step 10 → md_done never pulses, outputs return to reset values. A new MUL 3×4 after release → 12.
- Assert ex_kill at BUSY step 5 → md_stall drops that cycle, next state IDLE, no md_done. Then issue two back-to-back DIVU ops 9÷3 and 8÷2 → results 3 and 4, with done pulses 34 cycles apart.
